// File: rtl/cart_bus_arbiter_if.sv
// cart_bus_arbiter_if
//   Host-side request/response bundle for cart_bus_arbiter.
//   master : the host requester (ROM dump / save-RAM backup engine)
//   slave  : the arbiter
// Signals:
//   host_req          request, held with stable fields until host_ack
//   host_write        1 = write, 0 = read
//   host_address      16-bit cartridge address
//   host_wdata        8-bit write data
//   host_chip_select  chip select driven during the host access
//   host_ack          one-cycle completion pulse
//   host_rdata        read data, valid from host_ack onward
//   host_error        valid with host_ack; 1 = request rejected
//   host_owner        1 while the host drives the cartridge bus
`timescale 1ns/1ps
interface cart_bus_arbiter_if;
   logic        host_req;
   logic        host_write;
   logic [15:0] host_address;
   logic [7:0]  host_wdata;
   logic        host_chip_select;
   logic        host_ack;
   logic [7:0]  host_rdata;
   logic        host_error;
   logic        host_owner;

   modport master (
      output host_req, host_write, host_address, host_wdata, host_chip_select,
      input  host_ack, host_rdata, host_error, host_owner
   );

   modport slave (
      input  host_req, host_write, host_address, host_wdata, host_chip_select,
      output host_ack, host_rdata, host_error, host_owner
   );
endinterface

// File: rtl/cart_bus_arbiter.sv
// cart_bus_arbiter
//   Shares the physical cartridge bus between the Gameboy core and a host
//   requester. The core can never be stalled: whenever it drives a read or
//   write strobe it owns the pins in that same cycle. Host accesses start only
//   after IDLE_CYCLES consecutive core-idle cycles, last ACCESS_CYCLES cycles,
//   and are abandoned and retried from scratch if the core reclaims the bus.
// Configuration macro:
//   CART_ARB_HOST_WRITE_EN  defined: host writes are executed on the bus.
//                           undefined: host writes are acked at once with
//                           host_error = 1 and never touch the bus.
// Ports:
//   clock, reset              clk_4mhz domain, asynchronous active-high reset
//   gb_*                      core cartridge port (address, wdata, strobes, cs,
//                             gb_data_read returns the D pins combinationally)
//   host                      cart_bus_arbiter_if.slave request/response bundle
//   cart_*                    cartridge pin drivers (address, data out + oe,
//                             data in, active-low rd/wr, chip select)
`timescale 1ns/1ps
module cart_bus_arbiter #(
   parameter int IDLE_CYCLES   = 2,
   parameter int ACCESS_CYCLES = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [15:0]         gb_address,
   input  logic [7:0]          gb_data_write,
   input  logic                gb_read_enable,
   input  logic                gb_write_enable,
   input  logic                gb_chip_select,
   output logic [7:0]          gb_data_read,
   cart_bus_arbiter_if.slave   host,
   output logic [15:0]         cart_address,
   output logic [7:0]          cart_data_out,
   output logic                cart_data_oe,
   input  logic [7:0]          cart_data_in,
   output logic                cart_n_rd,
   output logic                cart_n_wr,
   output logic                cart_n_cs
);

   localparam int QW = $clog2(IDLE_CYCLES + 1);
   localparam int KW = $clog2(ACCESS_CYCLES + 1);
   localparam logic [QW-1:0] QUIET_LAST = QW'(IDLE_CYCLES - 1);
   localparam logic [KW-1:0] K_LAST     = KW'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_QUIET, S_ACCESS, S_ACK} state_t;

   state_t        state, state_next;
   logic [QW-1:0] quiet_count, quiet_next;
   logic [KW-1:0] access_k, access_k_next;
   logic [7:0]    rdata_q, rdata_next;
   logic          error_q, error_next;
   logic          gb_active;
   logic          host_owner;

   assign gb_active    = gb_read_enable | gb_write_enable;
   assign gb_data_read = cart_data_in;
   // Core priority is combinational so its strobe hits the pins without delay.
   assign host_owner   = (state == S_ACCESS) & ~gb_active;

   assign host.host_ack   = (state == S_ACK);
   assign host.host_error = error_q;
   assign host.host_rdata = rdata_q;
   assign host.host_owner = host_owner;

   // ---- state register ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         quiet_count <= '0;
         access_k    <= '0;
         rdata_q     <= 8'h00;
         error_q     <= 1'b0;
      end else begin
         state       <= state_next;
         quiet_count <= quiet_next;
         access_k    <= access_k_next;
         rdata_q     <= rdata_next;
         error_q     <= error_next;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_next    = state;
      quiet_next    = quiet_count;
      access_k_next = access_k;
      rdata_next    = rdata_q;
      error_next    = error_q;
      case (state)
         S_IDLE: begin
            if (host.host_req) begin
`ifdef CART_ARB_HOST_WRITE_EN
               state_next = S_QUIET;
               quiet_next = '0;
               error_next = 1'b0;
`else
               if (host.host_write) begin
                  // Writes are rejected outright; no bus activity at all.
                  state_next = S_ACK;
                  error_next = 1'b1;
               end else begin
                  state_next = S_QUIET;
                  quiet_next = '0;
                  error_next = 1'b0;
               end
`endif
            end
         end
         S_QUIET: begin
            if (gb_active) begin
               quiet_next = '0;
            end else if (quiet_count == QUIET_LAST) begin
               state_next    = S_ACCESS;
               access_k_next = '0;
            end else begin
               quiet_next = quiet_count + 1'b1;
            end
         end
         S_ACCESS: begin
            if (gb_active) begin
               // Core reclaimed the bus: abandon and wait for a fresh idle gap.
               state_next    = S_QUIET;
               quiet_next    = '0;
               access_k_next = '0;
            end else if (access_k == K_LAST) begin
               state_next = S_ACK;
               if (!host.host_write) rdata_next = cart_data_in;
            end else begin
               access_k_next = access_k + 1'b1;
            end
         end
         S_ACK: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ---- pin mux ----
   always_comb begin
      cart_address  = gb_address;
      cart_data_out = gb_data_write;
      cart_data_oe  = gb_write_enable;
      cart_n_rd     = ~gb_read_enable;
      cart_n_wr     = ~gb_write_enable;
      cart_n_cs     = gb_chip_select;
      if (host_owner) begin
         cart_address  = host.host_address;
         cart_n_cs     = host.host_chip_select;
         cart_data_out = host.host_wdata;
         if (host.host_write) begin
            // First and last access cycles are data setup and hold.
            cart_data_oe = 1'b1;
            cart_n_rd    = 1'b1;
            cart_n_wr    = (access_k == '0) || (access_k == K_LAST);
         end else begin
            cart_data_oe = 1'b0;
            cart_n_rd    = 1'b0;
            cart_n_wr    = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
`timescale 1ns/1ps
module tb_cart_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] gb_address;
   logic [7:0]  gb_data_write;
   logic        gb_read_enable;
   logic        gb_write_enable;
   logic        gb_chip_select;
   logic [7:0]  gb_data_read;
   logic [15:0] cart_address;
   logic [7:0]  cart_data_out;
   logic        cart_data_oe;
   logic [7:0]  cart_data_in;
   logic        cart_n_rd;
   logic        cart_n_wr;
   logic        cart_n_cs;

   cart_bus_arbiter_if hif();

   cart_bus_arbiter #(.IDLE_CYCLES(2), .ACCESS_CYCLES(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .gb_address      (gb_address),
      .gb_data_write   (gb_data_write),
      .gb_read_enable  (gb_read_enable),
      .gb_write_enable (gb_write_enable),
      .gb_chip_select  (gb_chip_select),
      .gb_data_read    (gb_data_read),
      .host            (hif.slave),
      .cart_address    (cart_address),
      .cart_data_out   (cart_data_out),
      .cart_data_oe    (cart_data_oe),
      .cart_data_in    (cart_data_in),
      .cart_n_rd       (cart_n_rd),
      .cart_n_wr       (cart_n_wr),
      .cart_n_cs       (cart_n_cs)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wd;
      logic        re, we, cs;
      logic [7:0]  din;
      logic [15:0] e_addr;
      logic [7:0]  e_dout;
      logic        e_oe, e_nrd, e_nwr, e_ncs;
      logic [7:0]  e_gbrd;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[1] = '{16'h0150, 8'h11, 1'b1, 1'b0, 1'b1, 8'h3C, 16'h0150, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
      vecs[2] = '{16'h2000, 8'h05, 1'b0, 1'b1, 1'b1, 8'hFF, 16'h2000, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF};
      vecs[3] = '{16'hA000, 8'h77, 1'b0, 1'b1, 1'b0, 8'h81, 16'hA000, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
      vecs[4] = '{16'hFFFF, 8'hC3, 1'b1, 1'b1, 1'b1, 8'h00, 16'hFFFF, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};

      reset = 1'b1;
      gb_address = 16'h0000; gb_data_write = 8'h00;
      gb_read_enable = 1'b0; gb_write_enable = 1'b0; gb_chip_select = 1'b0;
      cart_data_in = 8'h00;
      hif.host_req = 1'b0; hif.host_write = 1'b0; hif.host_address = 16'h0000;
      hif.host_wdata = 8'h00; hif.host_chip_select = 1'b0;

      // reset state
      tick(); settle();
      chk("rst_ack",   16'(hif.host_ack),   16'h0);
      chk("rst_err",   16'(hif.host_error), 16'h0);
      chk("rst_rdata", 16'(hif.host_rdata), 16'h00);
      chk("rst_owner", 16'(hif.host_owner), 16'h0);
      chk("rst_nrd",   16'(cart_n_rd),      16'h1);
      chk("rst_nwr",   16'(cart_n_wr),      16'h1);
      tick(); reset = 1'b0;

      // core pass-through table
      for (int i = 0; i < 5; i++) begin
         tick();
         gb_address = vecs[i].addr; gb_data_write = vecs[i].wd;
         gb_read_enable = vecs[i].re; gb_write_enable = vecs[i].we;
         gb_chip_select = vecs[i].cs; cart_data_in = vecs[i].din;
         settle();
         chk($sformatf("vec%0d_addr", i), cart_address,          vecs[i].e_addr);
         chk($sformatf("vec%0d_dout", i), 16'(cart_data_out),    16'(vecs[i].e_dout));
         chk($sformatf("vec%0d_oe", i),   16'(cart_data_oe),     16'(vecs[i].e_oe));
         chk($sformatf("vec%0d_nrd", i),  16'(cart_n_rd),        16'(vecs[i].e_nrd));
         chk($sformatf("vec%0d_nwr", i),  16'(cart_n_wr),        16'(vecs[i].e_nwr));
         chk($sformatf("vec%0d_ncs", i),  16'(cart_n_cs),        16'(vecs[i].e_ncs));
         chk($sformatf("vec%0d_gbrd", i), 16'(gb_data_read),     16'(vecs[i].e_gbrd));
         chk($sformatf("vec%0d_own", i),  16'(hif.host_owner),   16'h0);
      end
      tick();
      gb_read_enable = 1'b0; gb_write_enable = 1'b0; gb_chip_select = 1'b0;
      gb_address = 16'h1111;

      // uncontended read: request in cycle n, ack in n+7
      tick();
      hif.host_req = 1'b1; hif.host_write = 1'b0; hif.host_address = 16'h0134;
      hif.host_chip_select = 1'b1; cart_data_in = 8'h5A;
      settle();
      chk("rd_n_owner", 16'(hif.host_owner), 16'h0);
      for (int c = 1; c <= 7; c++) begin
         tick(); settle();
         chk($sformatf("rd_c%0d_ack", c),   16'(hif.host_ack),   16'(c == 7));
         chk($sformatf("rd_c%0d_owner", c), 16'(hif.host_owner), 16'(c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) begin
            chk($sformatf("rd_c%0d_addr", c), cart_address,     16'h0134);
            chk($sformatf("rd_c%0d_nrd", c),  16'(cart_n_rd),   16'h0);
            chk($sformatf("rd_c%0d_ncs", c),  16'(cart_n_cs),   16'h1);
         end
         if (c == 7) begin
            chk("rd_rdata", 16'(hif.host_rdata), 16'h5A);
            chk("rd_err",   16'(hif.host_error), 16'h0);
         end
      end
      tick(); hif.host_req = 1'b0; settle();
      chk("rd_after_ack", 16'(hif.host_ack), 16'h0);

      // host write
      tick();
      hif.host_req = 1'b1; hif.host_write = 1'b1; hif.host_address = 16'h2000;
      hif.host_wdata = 8'hA5; hif.host_chip_select = 1'b0; cart_data_in = 8'h99;
      settle();
      chk("wr_n_owner", 16'(hif.host_owner), 16'h0);
`ifdef CART_ARB_HOST_WRITE_EN
      for (int c = 1; c <= 7; c++) begin
         tick(); settle();
         chk($sformatf("wr_c%0d_ack", c),   16'(hif.host_ack),   16'(c == 7));
         chk($sformatf("wr_c%0d_owner", c), 16'(hif.host_owner), 16'(c >= 3 && c <= 6));
         chk($sformatf("wr_c%0d_oe", c),    16'(cart_data_oe),   16'(c >= 3 && c <= 6));
         chk($sformatf("wr_c%0d_nwr", c),   16'(cart_n_wr),      16'(!(c == 4 || c == 5)));
         chk($sformatf("wr_c%0d_nrd", c),   16'(cart_n_rd),      16'h1);
         if (c >= 3 && c <= 6) begin
            chk($sformatf("wr_c%0d_addr", c), cart_address,       16'h2000);
            chk($sformatf("wr_c%0d_dout", c), 16'(cart_data_out), 16'hA5);
         end
         if (c == 7) begin
            chk("wr_err",   16'(hif.host_error), 16'h0);
            chk("wr_rdata", 16'(hif.host_rdata), 16'h5A);
         end
      end
      tick(); hif.host_req = 1'b0; hif.host_write = 1'b0; settle();
      chk("wr_after_ack", 16'(hif.host_ack), 16'h0);
`else
      chk("wr_n_nwr", 16'(cart_n_wr),    16'h1);
      chk("wr_n_oe",  16'(cart_data_oe), 16'h0);
      tick(); settle();
      chk("wrrej_ack",   16'(hif.host_ack),   16'h1);
      chk("wrrej_err",   16'(hif.host_error), 16'h1);
      chk("wrrej_nwr",   16'(cart_n_wr),      16'h1);
      chk("wrrej_oe",    16'(cart_data_oe),   16'h0);
      chk("wrrej_owner", 16'(hif.host_owner), 16'h0);
      chk("wrrej_rdata", 16'(hif.host_rdata), 16'h5A);
      tick(); hif.host_req = 1'b0; hif.host_write = 1'b0; settle();
      chk("wrrej_after_ack", 16'(hif.host_ack), 16'h0);
      for (int c = 0; c < 4; c++) begin
         tick(); settle();
         chk($sformatf("wrrej_quiet%0d_owner", c), 16'(hif.host_owner), 16'h0);
         chk($sformatf("wrrej_quiet%0d_nwr", c),   16'(cart_n_wr),      16'h1);
         chk($sformatf("wrrej_quiet%0d_ack", c),   16'(hif.host_ack),   16'h0);
      end
`endif

      // abort: core read strobe at ACCESS k = 2 (cycle n+5)
      tick();
      hif.host_req = 1'b1; hif.host_write = 1'b0; hif.host_address = 16'h0140;
      hif.host_chip_select = 1'b1; cart_data_in = 8'h6B;
      for (int c = 1; c <= 4; c++) begin
         tick(); settle();
      end
      chk("ab_k1_owner", 16'(hif.host_owner), 16'h1);
      tick();
      gb_read_enable = 1'b1; gb_address = 16'h4000;
      settle();
      chk("ab_pulse_addr",  cart_address,          16'h4000);
      chk("ab_pulse_owner", 16'(hif.host_owner),   16'h0);
      chk("ab_pulse_nrd",   16'(cart_n_rd),        16'h0);
      chk("ab_pulse_ncs",   16'(cart_n_cs),        16'h0);
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 1) gb_read_enable = 1'b0;
         settle();
         chk($sformatf("ab_c%0d_ack", c),   16'(hif.host_ack),   16'(c == 7));
         chk($sformatf("ab_c%0d_owner", c), 16'(hif.host_owner), 16'(c >= 3 && c <= 6));
         if (c == 7) chk("ab_rdata", 16'(hif.host_rdata), 16'h6B);
      end
      tick(); hif.host_req = 1'b0; settle();
      chk("ab_after_ack", 16'(hif.host_ack), 16'h0);

      // core priority: core write held for 20 cycles with a read pending
      tick();
      hif.host_req = 1'b1; hif.host_address = 16'h0150; cart_data_in = 8'h12;
      gb_write_enable = 1'b1; gb_address = 16'h2100; gb_data_write = 8'h01;
      settle();
      chk("cp_c0_owner", 16'(hif.host_owner), 16'h0);
      for (int c = 1; c <= 19; c++) begin
         tick(); settle();
         chk($sformatf("cp_c%0d_owner", c), 16'(hif.host_owner), 16'h0);
         chk($sformatf("cp_c%0d_nwr", c),   16'(cart_n_wr),      16'h0);
      end
      tick(); gb_write_enable = 1'b0; settle();
      chk("cp_idle0_owner", 16'(hif.host_owner), 16'h0);
      tick(); settle();
      chk("cp_idle1_owner", 16'(hif.host_owner), 16'h0);
      tick(); settle();
      chk("cp_start_owner", 16'(hif.host_owner), 16'h1);
      chk("cp_start_addr",  cart_address,        16'h0150);
      chk("cp_start_nrd",   16'(cart_n_rd),      16'h0);
      for (int c = 0; c < 3; c++) begin
         tick(); settle();
         chk($sformatf("cp_acc%0d_ack", c), 16'(hif.host_ack), 16'h0);
      end
      tick(); settle();
      chk("cp_ack",   16'(hif.host_ack),   16'h1);
      chk("cp_rdata", 16'(hif.host_rdata), 16'h12);
      tick(); hif.host_req = 1'b0; settle();

      // reset during ACCESS k = 2
      tick();
      hif.host_req = 1'b1; hif.host_address = 16'h0134; cart_data_in = 8'h44;
      gb_address = 16'h3000;
      for (int c = 1; c <= 5; c++) begin
         tick(); settle();
      end
      chk("rs_k2_owner", 16'(hif.host_owner), 16'h1);
      chk("rs_k2_nrd",   16'(cart_n_rd),      16'h0);
      reset = 1'b1;
      #1;
      chk("rs_owner", 16'(hif.host_owner), 16'h0);
      chk("rs_nrd",   16'(cart_n_rd),      16'h1);
      chk("rs_addr",  cart_address,        16'h3000);
      chk("rs_ack",   16'(hif.host_ack),   16'h0);
      chk("rs_rdata", 16'(hif.host_rdata), 16'h00);
      hif.host_req = 1'b0;
      tick(); settle();
      chk("rs_hold_ack", 16'(hif.host_ack), 16'h0);
      tick(); reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick(); settle();
         chk($sformatf("rs_post%0d_ack", c),   16'(hif.host_ack),   16'h0);
         chk($sformatf("rs_post%0d_owner", c), 16'(hif.host_owner), 16'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cart_bus_arbiter.md
# cart_bus_arbiter

Shares the physical cartridge bus between the Gameboy core and a host-side requester, e.g. a ROM dump or save-RAM backup engine. The Gameboy core cannot be stalled, so it always owns the bus whenever it drives a strobe. Host accesses are granted only in observed idle gaps. A host access is aborted and retried whenever the core reclaims the bus. The block sits between the `Gameboy` cartridge port and the cartridge pin drivers, in the `clk_4mhz` domain.

## Interface
Parameters:
- IDLE_CYCLES, 2: consecutive core-idle cycles required before a host access may start (>=1).
- ACCESS_CYCLES, 4: length of one host bus access in cycles (>=3).

Ports:
- clock  in  1  Gameboy clock (`clk_4mhz`).
- reset  in  1  Asynchronous, active-high.
- gb_address  in  16  Core cartridge address.
- gb_data_write  in  8  Core write data.
- gb_read_enable  in  1  Core read strobe.
- gb_write_enable  in  1  Core write strobe.
- gb_chip_select  in  1  Core chip select.
- gb_data_read  out  8  Cartridge data returned to the core.
- host_req  in  1  Host request; held with stable fields until host_ack.
- host_write  in  1  1 = write, 0 = read.
- host_address  in  16  Host address.
- host_wdata  in  8  Host write data.
- host_chip_select  in  1  Host chip select.
- host_ack  out  1  One-cycle completion pulse.
- host_rdata  out  8  Read data; valid from host_ack onward.
- host_error  out  1  Valid with host_ack; 1 = request rejected.
- host_owner  out  1  1 while the host drives the cartridge bus.
- cart_address  out  16  Cartridge address pins.
- cart_data_out  out  8  Data to drive onto the cartridge D pins.
- cart_data_oe  out  1  D-pin tristate enable.
- cart_data_in  in  8  Sampled D pins.
- cart_n_rd  out  1  Active-low read strobe.
- cart_n_wr  out  1  Active-low write strobe.
- cart_n_cs  out  1  Chip select, passed with core polarity.

## Operation
- gb_active = gb_read_enable | gb_write_enable.
- gb_data_read = cart_data_in at all times (combinational).
- Bus mux:
  - host_owner = (state==ACCESS) & !gb_active, combinational.
  - When the core owns the bus: cart_address = gb_address, cart_data_out = gb_data_write, cart_data_oe = gb_write_enable, cart_n_rd = ~gb_read_enable, cart_n_wr = ~gb_write_enable, cart_n_cs = gb_chip_select.
- Host drive, with k = access counter 0..ACCESS_CYCLES-1:
  - cart_address = host_address and cart_n_cs = host_chip_select throughout.
  - Read: cart_n_rd = 0 throughout the access. cart_data_in is captured into host_rdata at k = ACCESS_CYCLES-1.
  - Write: cart_data_oe = 1 throughout. cart_n_wr = 0 only for k in 1..ACCESS_CYCLES-2, giving one cycle each of setup and hold.
- State machine:
  - IDLE: on host_req, go to QUIET with quiet count = 0.
  - QUIET: the count increments on each idle core cycle and clears to 0 on gb_active. At count IDLE_CYCLES-1 with the core idle, go to ACCESS with k = 0.
  - ACCESS: k increments each cycle. After k = ACCESS_CYCLES-1, go to ACK. If gb_active in any ACCESS cycle, the core gets the bus in that same cycle; the state returns to QUIET with count 0 and the access restarts from k = 0 later.
  - ACK: host_ack = 1 for exactly one cycle, then go to IDLE.
- Aborted host writes may partially strobe cart_n_wr. Retries repeat the write; host writes must be idempotent (MBC registers, SRAM).
- The host deasserts host_req in the cycle after host_ack. A req still high in IDLE starts a new transaction.

## Timing
- Reset values: state IDLE, host_ack 0, host_error 0, host_rdata 0x00, counters 0. All cart_* outputs follow the core path.
- Uncontended latency: host_req first high in cycle n (state IDLE) gives host_ack in cycle n+1+IDLE_CYCLES+ACCESS_CYCLES. With defaults, that is n+7.
- The core never waits: its strobe reaches the pins in the same cycle in every state.
- Reset mid-ACCESS releases the bus to the core path immediately, asynchronously. No ack is issued.
- host_rdata holds its value until the next completed read.

## Configuration
- CART_ARB_HOST_WRITE_EN defined: host writes execute as described above, with host_error = 0.
- Not defined:
  - A request with host_write = 1 goes IDLE → ACK directly, acking in cycle n+1 with host_error = 1.
  - No bus activity occurs for that request, and host_owner is never asserted for it.
  - Host reads are unaffected.

## Test plan
- Reset mid-operation: assert reset during ACCESS k = 2 → same-cycle cart_n_rd = ~gb_read_enable, host_ack stays 0, host_rdata = 0x00.
- Uncontended read: core idle, cart_data_in = 0x5A, host read of 0x0134 at n → cart_address = 0x0134 and cart_n_rd = 0 for cycles n+3..n+6, host_ack at n+7, host_rdata = 0x5A, host_error = 0.
- Uncontended write, macro defined: host write of 0xA5 to 0x2000 → cart_data_oe = 1 for 4 cycles, cart_n_wr = 0 for exactly the middle 2, host_ack with host_error = 0.
- Abort: gb_read_enable pulses at ACCESS k = 2 → in the same cycle cart_address = gb_address and host_owner = 0. The access restarts after 2 idle cycles, and host_ack arrives ≥ 7 cycles after the pulse.
- Core priority: gb_active held high for 20 cycles with a host request pending → host_owner = 0 throughout; the access starts 2 cycles after the core goes idle.
- Macro undefined: host write request at n → host_ack and host_error = 1 at n+1; cart_n_wr stays 1 and cart_data_oe stays 0.
